// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller.
// game_state_t values 0..2 match the older single-level encoding.
package game_pkg;

  typedef enum logic [2:0] {
    WELCOME     = 3'd0,
    PLAY        = 3'd1,
    GAME_OVER   = 3'd2,
    PAUSE       = 3'd3,
    LEVEL_CLEAR = 3'd4
  } game_state_t;

  // Returns a+b, clamped to cap; callers pass the cap for their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] cap);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, cap}) return cap;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/powerup_timer.sv
// One power-up countdown channel; active while the count is nonzero.
// Priority: clear, then load, then tick.
module powerup_timer #(
  parameter int unsigned TIMER_W = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadValue,
  input  logic               tick,
  input  logic               clear,
  output logic               active
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = loadValue;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) count_q <= '0;
    else         count_q <= count_d;
  end

  assign active = (count_q != '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Multi-level game-flow controller: owns state, lives, score, level and power-up timers.
// All score/lives/time arithmetic saturates.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_POWERUPS  = 4,
  parameter int unsigned GRACE_CH      = 3,
  parameter int unsigned POWERUP_TIME  = 5,
  parameter int unsigned GRACE_TIME    = 3,
  parameter int unsigned TIMER_W       = 4,
  parameter int unsigned INITIAL_LIVES = 3,
  parameter int unsigned MAX_LIVES     = 4,
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned HIT_QUANTUM   = 10,
  parameter int unsigned TIME_QUANTUM  = 1,
  parameter int unsigned LEVEL_BONUS   = 100,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned TIME_W        = 12,
  localparam int unsigned LEVEL_W      = $clog2(NUM_LEVELS),
  localparam int unsigned LIVES_W      = $clog2(MAX_LIVES + 1)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startKey,
  input  logic                    pauseKey,
  input  logic                    secTick,
  input  logic                    hitPlayer,
  input  logic                    hitBall,
  input  logic [1:0]              ballType,
  input  logic                    levelCleared,
  input  logic                    lifeGrant,
  input  logic [NUM_POWERUPS-1:0] powerupGrant,
  output logic [2:0]              gameState,
  output logic [LEVEL_W-1:0]      level,
  output logic [LIVES_W-1:0]      lives,
  output logic [SCORE_W-1:0]      score,
  output logic [SCORE_W-1:0]      maxScore,
  output logic [TIME_W-1:0]       gameTime,
  output logic [NUM_POWERUPS-1:0] powerupActive,
  output logic                    playEnable,
  output logic                    levelStart,
  output logic                    playerReset,
  output logic                    gameWon
);

  localparam logic [31:0] SCORE_MAX = 32'({SCORE_W{1'b1}});
  localparam logic [31:0] TIME_MAX  = 32'({TIME_W{1'b1}});

  game_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d, max_q, max_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               won_q, won_d;
  logic               level_start_q, level_start_d;
  logic               player_reset_q, player_reset_d;
  logic               hit_ok, tick_en, grant_en, timer_clear;
  logic [2:0]         ball_mult;
  logic [31:0]        hit_points;

  assign ball_mult  = {1'b0, ballType} + 3'd1;
  assign hit_points = 32'(ball_mult) * HIT_QUANTUM;
  assign grant_en   = (state_q == PLAY);
  assign tick_en    = (state_q == PLAY) && secTick;

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    lives_d        = lives_q;
    score_d        = score_q;
    time_d         = time_q;
    won_d          = won_q;
    level_start_d  = 1'b0;
    player_reset_d = 1'b0;
    timer_clear    = 1'b0;
    hit_ok         = 1'b0;
    case (state_q)
      WELCOME: begin
        if (startKey) begin
          state_d       = PLAY;
          level_d       = '0;
          lives_d       = LIVES_W'(INITIAL_LIVES);
          score_d       = '0;
          time_d        = '0;
          won_d         = 1'b0;
          level_start_d = 1'b1;
          timer_clear   = 1'b1;
        end
      end
      PLAY: begin
        hit_ok = hitPlayer && !powerupActive[GRACE_CH];
        if (secTick) begin
          time_d  = TIME_W'(sat_add(32'(time_q), 32'd1, TIME_MAX));
          score_d = SCORE_W'(sat_add(32'(score_q), TIME_QUANTUM, SCORE_MAX));
        end
        if (hitBall) score_d = SCORE_W'(sat_add(32'(score_d), hit_points, SCORE_MAX));
        // A hit and a life grant in the same cycle cancel out on the lives count.
        if (hit_ok && !lifeGrant)      lives_d = lives_q - 1'b1;
        else if (!hit_ok && lifeGrant) lives_d = LIVES_W'(sat_add(32'(lives_q), 32'd1, MAX_LIVES));
        player_reset_d = hit_ok;
        if (hit_ok && !lifeGrant && (lives_q == LIVES_W'(1))) begin
          state_d     = GAME_OVER;
          timer_clear = 1'b1;
        end else if (levelCleared) begin
          score_d     = SCORE_W'(sat_add(32'(score_d), LEVEL_BONUS, SCORE_MAX));
          state_d     = LEVEL_CLEAR;
          timer_clear = 1'b1;
        end else if (pauseKey) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pauseKey) state_d = PLAY;
      end
      LEVEL_CLEAR: begin
        if (startKey) begin
          if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
            won_d   = 1'b1;
            state_d = GAME_OVER;
          end else begin
            level_d       = level_q + 1'b1;
            time_d        = '0;
            timer_clear   = 1'b1;
            state_d       = PLAY;
            level_start_d = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (startKey) begin
          state_d = WELCOME;
          won_d   = 1'b0;
        end
      end
      default: state_d = WELCOME;
    endcase
    max_d = (score_d > max_q) ? score_d : max_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= WELCOME;
      level_q        <= '0;
      lives_q        <= LIVES_W'(INITIAL_LIVES);
      score_q        <= '0;
      max_q          <= '0;
      time_q         <= '0;
      won_q          <= 1'b0;
      level_start_q  <= 1'b0;
      player_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      max_q          <= max_d;
      time_q         <= time_d;
      won_q          <= won_d;
      level_start_q  <= level_start_d;
      player_reset_q <= player_reset_d;
    end
  end

  for (genvar i = 0; i < int'(NUM_POWERUPS); i++) begin : g_pu
    logic               ld;
    logic [TIMER_W-1:0] ld_val;
    if (i == int'(GRACE_CH)) begin : g_grace
      assign ld     = (grant_en && powerupGrant[i]) || hit_ok;
      assign ld_val = hit_ok ? TIMER_W'(GRACE_TIME) : TIMER_W'(POWERUP_TIME);
    end else begin : g_plain
      assign ld     = grant_en && powerupGrant[i];
      assign ld_val = TIMER_W'(POWERUP_TIME);
    end
    powerup_timer #(
      .TIMER_W(TIMER_W)
    ) u_timer (
      .clk      (clk),
      .resetN   (resetN),
      .load     (ld),
      .loadValue(ld_val),
      .tick     (tick_en),
      .clear    (timer_clear),
      .active   (powerupActive[i])
    );
  end

  assign gameState   = state_q;
  assign level       = level_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign maxScore    = max_q;
  assign gameTime    = time_q;
  assign playEnable  = (state_q == PLAY);
  assign levelStart  = level_start_q;
  assign playerReset = player_reset_q;
  assign gameWon     = won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; expected values are hand-computed constants.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startKey, pauseKey, secTick, hitPlayer, hitBall, levelCleared, lifeGrant;
  logic [1:0] ballType;
  logic [3:0] powerupGrant;
  logic [2:0] gameState;
  logic [1:0] level;
  logic [2:0] lives;
  logic [15:0] score, maxScore;
  logic [11:0] gameTime;
  logic [3:0] powerupActive;
  logic       playEnable, levelStart, playerReset, gameWon;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_flow_ctrl u_dut (
    .clk          (clk),
    .resetN       (resetN),
    .startKey     (startKey),
    .pauseKey     (pauseKey),
    .secTick      (secTick),
    .hitPlayer    (hitPlayer),
    .hitBall      (hitBall),
    .ballType     (ballType),
    .levelCleared (levelCleared),
    .lifeGrant    (lifeGrant),
    .powerupGrant (powerupGrant),
    .gameState    (gameState),
    .level        (level),
    .lives        (lives),
    .score        (score),
    .maxScore     (maxScore),
    .gameTime     (gameTime),
    .powerupActive(powerupActive),
    .playEnable   (playEnable),
    .levelStart   (levelStart),
    .playerReset  (playerReset),
    .gameWon      (gameWon)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, then drop every one-cycle pulse input.
  task automatic clk_step();
    @(posedge clk);
    #1;
    startKey = 0; pauseKey = 0; secTick = 0; hitPlayer = 0;
    hitBall = 0; levelCleared = 0; lifeGrant = 0; powerupGrant = '0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      secTick = 1;
      clk_step();
    end
  endtask

  task automatic hit_and_recover();
    hitPlayer = 1;
    clk_step();
    ticks(3);
  endtask

  initial begin
    resetN = 0; ballType = 0;
    startKey = 0; pauseKey = 0; secTick = 0; hitPlayer = 0;
    hitBall = 0; levelCleared = 0; lifeGrant = 0; powerupGrant = '0;
    #12;
    check_eq("rst_state", 32'(gameState), 0);
    check_eq("rst_lives", 32'(lives), 3);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_score", 32'(score), 0);
    check_eq("rst_pu", 32'(powerupActive), 0);
    check_eq("rst_play_en", 32'(playEnable), 0);
    @(negedge clk);
    resetN = 1;
    clk_step();

    // Start, 3 ticks, size-2 ball hit
    startKey = 1; clk_step();
    check_eq("start_state", 32'(gameState), 1);
    check_eq("start_lvl_start", 32'(levelStart), 1);
    check_eq("start_play_en", 32'(playEnable), 1);
    ticks(1);
    check_eq("lvl_start_once", 32'(levelStart), 0);
    ticks(2);
    ballType = 2; hitBall = 1; clk_step();
    check_eq("score_33", 32'(score), 33);
    check_eq("time_3", 32'(gameTime), 3);
    check_eq("max_33", 32'(maxScore), 33);

    // Hit, hit during grace ignored, grace expires after 3 ticks
    hitPlayer = 1; clk_step();
    check_eq("hit_lives", 32'(lives), 2);
    check_eq("hit_reset", 32'(playerReset), 1);
    check_eq("grace_on", 32'(powerupActive), 4'b1000);
    hitPlayer = 1; clk_step();
    check_eq("grace_lives", 32'(lives), 2);
    check_eq("grace_no_reset", 32'(playerReset), 0);
    ticks(2);
    check_eq("grace_2t", 32'(powerupActive), 4'b1000);
    ticks(1);
    check_eq("grace_off", 32'(powerupActive), 0);
    check_eq("score_36", 32'(score), 36);

    // Grant coincident with tick, pause freezes
    powerupGrant = 4'b0001; secTick = 1; clk_step();
    check_eq("grant_on", 32'(powerupActive), 4'b0001);
    check_eq("grant_score", 32'(score), 37);
    ticks(2);
    pauseKey = 1; clk_step();
    check_eq("pause_state", 32'(gameState), 3);
    check_eq("pause_play_en", 32'(playEnable), 0);
    ticks(3);
    check_eq("pause_score", 32'(score), 39);
    check_eq("pause_time", 32'(gameTime), 9);
    check_eq("pause_pu", 32'(powerupActive), 4'b0001);
    pauseKey = 1; clk_step();
    check_eq("resume_state", 32'(gameState), 1);
    check_eq("resume_no_lvl_start", 32'(levelStart), 0);
    ticks(2);
    check_eq("pu_4t", 32'(powerupActive), 4'b0001);
    ticks(1);
    check_eq("pu_5t", 32'(powerupActive), 0);
    check_eq("score_42", 32'(score), 42);

    // Three level clears then win
    levelCleared = 1; clk_step();
    check_eq("lc_state", 32'(gameState), 4);
    check_eq("lc_bonus", 32'(score), 142);
    startKey = 1; clk_step();
    check_eq("lvl1", 32'(level), 1);
    check_eq("lvl1_start", 32'(levelStart), 1);
    check_eq("lvl1_time", 32'(gameTime), 0);
    check_eq("lvl1_lives", 32'(lives), 2);
    levelCleared = 1; clk_step();
    startKey = 1; clk_step();
    check_eq("lvl2", 32'(level), 2);
    levelCleared = 1; clk_step();
    startKey = 1; clk_step();
    check_eq("win_state", 32'(gameState), 2);
    check_eq("win_flag", 32'(gameWon), 1);
    check_eq("win_score", 32'(score), 342);
    startKey = 1; clk_step();
    check_eq("welcome_state", 32'(gameState), 0);
    check_eq("welcome_won", 32'(gameWon), 0);
    check_eq("welcome_max", 32'(maxScore), 342);

    // Life saturation, hit+grant, last-life hit beats levelCleared
    startKey = 1; clk_step();
    check_eq("restart_score", 32'(score), 0);
    check_eq("restart_level", 32'(level), 0);
    lifeGrant = 1; clk_step();
    check_eq("life_up", 32'(lives), 4);
    lifeGrant = 1; clk_step();
    check_eq("life_sat", 32'(lives), 4);
    hitPlayer = 1; lifeGrant = 1; clk_step();
    check_eq("hit_grant_lives", 32'(lives), 4);
    check_eq("hit_grant_grace", 32'(powerupActive), 4'b1000);
    check_eq("hit_grant_reset", 32'(playerReset), 1);
    ticks(3);
    hit_and_recover();
    hit_and_recover();
    hit_and_recover();
    check_eq("last_life", 32'(lives), 1);
    hitPlayer = 1; levelCleared = 1; clk_step();
    check_eq("go_state", 32'(gameState), 2);
    check_eq("go_lives", 32'(lives), 0);
    check_eq("go_no_bonus", 32'(score), 12);
    check_eq("go_won", 32'(gameWon), 0);
    check_eq("go_pu_clear", 32'(powerupActive), 0);
    startKey = 1; clk_step();

    // Score saturation; maxScore survives a round trip, clears on reset
    startKey = 1; clk_step();
    ballType = 3;
    for (int k = 0; k < 1700; k++) begin
      hitBall = 1;
      clk_step();
    end
    check_eq("score_sat", 32'(score), 65535);
    hitBall = 1; secTick = 1; clk_step();
    check_eq("score_sat2", 32'(score), 65535);
    check_eq("max_sat", 32'(maxScore), 65535);
    hit_and_recover();
    hit_and_recover();
    hitPlayer = 1; clk_step();
    check_eq("go2_state", 32'(gameState), 2);
    startKey = 1; clk_step();
    startKey = 1; clk_step();
    check_eq("new_game_score", 32'(score), 0);
    check_eq("max_kept", 32'(maxScore), 65535);
    #3;
    resetN = 0;
    #1;
    check_eq("async_state", 32'(gameState), 0);
    check_eq("async_max", 32'(maxScore), 0);
    check_eq("async_lives", 32'(lives), 3);
    @(negedge clk);
    resetN = 1;
    clk_step();
    check_eq("post_rst_state", 32'(gameState), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller, successor to the single-level game state machine. It adds multiple levels, a pause state and an N-channel power-up timer bank with a dedicated post-hit grace channel. All score arithmetic saturates. Sits between the keyboard/collision front-end and the drawing and mover blocks, and is the single owner of lives, score, level and power-up status.

## Interface
- NUM_POWERUPS, 4: power-up channels, indices 0..NUM_POWERUPS-1
- GRACE_CH, 3: channel also loaded on player hit (immortality)
- POWERUP_TIME, 5: secTick count a granted power-up lasts
- GRACE_TIME, 3: secTick count of post-hit grace
- TIMER_W, 4: per-channel timer width
- INITIAL_LIVES, 3; MAX_LIVES, 4: lives at game start / saturation cap
- NUM_LEVELS, 3: levels before a win
- HIT_QUANTUM, 10; TIME_QUANTUM, 1; LEVEL_BONUS, 100: score increments
- SCORE_W, 16; TIME_W, 12: score / gameTime widths
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startKey, pauseKey  in  1 each  one-cycle key pulses (edge-detected upstream)
- secTick  in  1  one-cycle pulse per second
- hitPlayer  in  1  player/ball collision
- hitBall  in  1  rope/ball collision; ballType  in  2  size of hit ball
- levelCleared  in  1  no balls remain
- lifeGrant  in  1  extra-life present collected
- powerupGrant  in  NUM_POWERUPS  one-hot power-up collected
- gameState  out  3  game_state_t encoding
- level  out  $clog2(NUM_LEVELS)  current level
- lives  out  $clog2(MAX_LIVES+1)
- score, maxScore  out  SCORE_W
- gameTime  out  TIME_W  seconds in current level
- powerupActive  out  NUM_POWERUPS
- playEnable  out  1  high iff state is PLAY
- levelStart, playerReset  out  1  one-cycle pulses
- gameWon  out  1  final level cleared

## Operation
- All outputs are registered. Reset values: state WELCOME, lives=INITIAL_LIVES, level=0; every other output 0. maxScore is cleared only by resetN.
- WELCOME: startKey -> PLAY. On entry to PLAY: level=0, lives=INITIAL_LIVES, score=0, gameTime=0, all timers 0, gameWon=0.
- PLAY:
  - secTick: gameTime+1 (saturating), score+=TIME_QUANTUM.
  - hitBall: score+=(ballType+1)*HIT_QUANTUM. When both occur in the same cycle, both increments apply.
  - hitPlayer while !powerupActive[GRACE_CH]: lives-1, grace timer:=GRACE_TIME, playerReset pulses. A hit during grace is ignored.
  - lifeGrant: lives+1, saturating at MAX_LIVES. Hit and lifeGrant in the same cycle: net lives unchanged, grace loaded, playerReset pulses.
  - Hit with lives==1 (no lifeGrant): lives=0, next state GAME_OVER. This has priority over levelCleared and pauseKey.
  - levelCleared: score+=LEVEL_BONUS, next state LEVEL_CLEAR. This has priority over pauseKey.
  - pauseKey: next state PAUSE.
- PAUSE: only pauseKey (-> PLAY) is honoured. Timers, gameTime and score are frozen. pauseKey does not emit levelStart.
- LEVEL_CLEAR: on startKey:
  - If level==NUM_LEVELS-1: gameWon=1, next state GAME_OVER.
  - Otherwise: level+1, gameTime=0, timers cleared, next state PLAY. Lives and score are kept.
- GAME_OVER: startKey -> WELCOME. gameWon is held until WELCOME is entered.
- Power-up channel i:
  - powerupGrant[i] loads POWERUP_TIME.
  - powerupActive[i] = (timer != 0).
  - In PLAY, each secTick decrements any nonzero timer, so a power-up stays active for exactly the loaded number of ticks.
  - Grant and secTick in the same cycle: the grant reloads and the tick is ignored on that channel.
  - Grace load on GRACE_CH obeys the same rule and uses GRACE_TIME.
  - Timers are cleared on leaving PLAY/PAUSE to any state other than PAUSE/PLAY.
- maxScore is updated every cycle to max(maxScore, next score), so it has no lag relative to score.
- Arithmetic: all adders saturate at all-ones of their width. ballType+1 is computed in 3 bits.

## Timing
- Input to registered output: 1 cycle. A state change is visible the cycle after the triggering pulse.
- levelStart is high for exactly the first cycle in PLAY after WELCOME or LEVEL_CLEAR.
- playerReset is high for the cycle after the qualifying hit.
- resetN mid-operation: all outputs take their reset values immediately (asynchronous). Release is sampled on the next clk.
- Inputs are assumed synchronous to clk. Pulses longer than one cycle act once per cycle.

## Structure
- game_pkg holds:
  - game_state_t: WELCOME=0, PLAY=1, GAME_OVER=2, PAUSE=3, LEVEL_CLEAR=4. Values 0..2 are unchanged from the previous gameState encoding.
  - A saturating-add function used by score, lives and gameTime.
- Sub-module powerup_timer: one channel with load, loadValue, tick, clear, and active. It is instantiated NUM_POWERUPS times via generate. The GRACE_CH instance ORs the hit-load into its load input and muxes GRACE_TIME as loadValue.

## Test plan
- Reset, startKey, 3 secTicks, hitBall with ballType=2 -> score=33, gameTime=3, levelStart pulsed once.
- hitPlayer, then hitPlayer again 1 cycle later -> lives 3→2 only, powerupActive[3]=1. After 3 secTicks -> powerupActive[3]=0.
- powerupGrant=4'b0001 coincident with secTick -> timer=5. Active for exactly 5 further secTicks. Pause mid-way freezes the count.
- Lives=1, hitPlayer and levelCleared in the same cycle -> GAME_OVER, lives=0, no LEVEL_BONUS added.
- Clear levels 0,1,2 with startKey each -> level 0→1→2, then GAME_OVER with gameWon=1, score includes 300 bonus.
- Score preset near 65535, hitBall -> score=65535 (saturates). maxScore survives GAME_OVER→WELCOME and clears only on resetN.
